// File: rtl/mem_add_seq.sv
// Multicycle add-and-store controller for the lab 5 data memory: fetches two
// operands and a destination pointer, adds them, and writes the sum back.
module mem_add_seq #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int ADDR_A   = 48,
  parameter int ADDR_B   = 49,
  parameter int ADDR_PTR = 50
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry
);

  typedef enum logic [2:0] {
    IDLE,
    LD_A,
    LD_B,
    LD_P,
    ADD,
    WR,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [AW-1:0] ptr;

  // The pointer word only supplies an address; its upper bits are dropped.
  logic unused_ptr_hi;
  assign unused_ptr_hi = ^mem_rdata[DW-1:AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      ptr    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        LD_A:    op_a <= mem_rdata;
        LD_B:    op_b <= mem_rdata;
        LD_P:    ptr  <= mem_rdata[AW-1:0];
        ADD:     {carry, result} <= {1'b0, op_a} + {1'b0, op_b};
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_addr   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LD_A;
      end
      LD_A: begin
        mem_addr   = AW'(ADDR_A);
        busy       = 1'b1;
        state_next = LD_B;
      end
      LD_B: begin
        mem_addr   = AW'(ADDR_B);
        busy       = 1'b1;
        state_next = LD_P;
      end
      LD_P: begin
        mem_addr   = AW'(ADDR_PTR);
        busy       = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        busy       = 1'b1;
        state_next = WR;
      end
      WR: begin
        mem_addr   = ptr;
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset on the WR edge must suppress the write, not just the next state.
  assign mem_we    = (state == WR) && !reset;
  assign mem_wdata = result;

endmodule

// File: tb/tb_mem_add_seq.sv
// Bench for mem_add_seq: a behavioural memory, a run-level reference model
// feeding a scoreboard, and a monitor that checks every cycle.
module tb_mem_add_seq;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;

  always #5 clk = ~clk;

  mem_add_seq #(
    .AW(AW), .DW(DW), .ADDR_A(48), .ADDR_B(49), .ADDR_PTR(50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .result(result), .carry(carry)
  );

  // memory seen by the DUT, plus a bench-only backdoor write port
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  typedef struct {
    int            k;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_k = -100;
  bit   active = 1'b0;
  int   next_accept = 0;
  int   accepts = 0;
  int   done_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run-level model: a run is accepted on a start edge when the previous one
  // has fully finished (7 cycles later), and its result comes from plain
  // arithmetic on the model's memory image.
  int   s_tmp;
  exp_t e_tmp;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      sb.delete();
      active      = 1'b0;
      next_accept = cyc + 1;
    end else if (start && cyc >= next_accept) begin
      s_tmp      = int'(ref_mem[48]) + int'(ref_mem[49]);
      e_tmp.k    = cyc;
      e_tmp.addr = ref_mem[50][AW-1:0];
      e_tmp.data = s_tmp[15:0];
      e_tmp.cy   = s_tmp[16];
      sb.push_back(e_tmp);
      acc_k       = cyc;
      active      = 1'b1;
      next_accept = cyc + 7;
      accepts     = accepts + 1;
    end
  end

  // Monitor: cycle offset since acceptance gives the expected visible state.
  int            m_off;
  logic          m_busy;
  logic          m_done;
  logic          m_we;
  logic [AW-1:0] m_addr;
  always @(posedge clk) begin
    #3;
    m_off  = cyc - acc_k;
    m_busy = active && m_off >= 0 && m_off <= 4;
    m_done = active && m_off == 5;
    m_we   = active && m_off == 4;
    m_addr = '0;
    if (active) begin
      case (m_off)
        0: m_addr = 8'd48;
        1: m_addr = 8'd49;
        2: m_addr = 8'd50;
        4: if (sb.size() != 0) m_addr = sb[0].addr;
        default: m_addr = '0;
      endcase
    end
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
    checkOutput("mem_we", mem_we, m_we);
    checkOutput("mem_addr", mem_addr, m_addr);
    if (mem_we && sb.size() != 0) checkOutput("mem_wdata", mem_wdata, sb[0].data);
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        checkOutput("done without pending run", 1, 0);
      end else begin
        e_tmp = sb.pop_front();
        checkOutput("result", result, e_tmp.data);
        checkOutput("carry", carry, e_tmp.cy);
        checkOutput("stored sum", mem[e_tmp.addr], e_tmp.data);
        ref_mem[e_tmp.addr] = e_tmp.data;
      end
    end
  end

  task automatic bdWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic applyStimulus(input int hold);
    @(negedge clk);
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    while (active && cyc < acc_k + 6) @(negedge clk);
    checkOutput("runs drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic checkMemory(input string name);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    checkOutput(name, diffs, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int runs_before;
  int dones_before;
  int guard;
  logic [DW-1:0] rnd;

  initial begin
    for (int i = 0; i < 256; i++) bdWrite(AW'(i), DW'($urandom));
    bdWrite(8'd48, 16'h1234);
    bdWrite(8'd49, 16'h789A);
    bdWrite(8'd50, 16'd128);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset carry", carry, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_we", mem_we, 0);

    // default image
    applyStimulus(1);
    waitIdle();
    checkOutput("default mem[128]", mem[128], 16'h8ACE);
    checkOutput("default result", result, 16'h8ACE);
    checkOutput("default carry", carry, 0);

    // wraparound with carry
    bdWrite(8'd48, 16'hFFFF);
    bdWrite(8'd49, 16'h0002);
    applyStimulus(1);
    waitIdle();
    checkOutput("wrap mem[128]", mem[128], 16'h0001);
    checkOutput("wrap carry", carry, 1);

    // upper pointer bits ignored
    bdWrite(8'd48, 16'h1234);
    bdWrite(8'd50, 16'h1280);
    applyStimulus(1);
    waitIdle();
    checkOutput("ptr hi mem[0x80]", mem[128], 16'h1236);
    checkMemory("ptr hi memory image");

    // start while busy, then held high
    bdWrite(8'd49, 16'h789A);
    bdWrite(8'd50, 16'd128);
    runs_before  = accepts;
    dones_before = done_count;
    applyStimulus(1);
    @(negedge clk);
    applyStimulus(1);
    applyStimulus(20);
    waitIdle();
    checkOutput("held start runs", accepts - runs_before, 4);
    checkOutput("held start dones", done_count - dones_before, 4);

    // reset during WR
    bdWrite(8'd48, 16'h0101);
    applyStimulus(1);
    guard = 0;
    while (cyc != acc_k + 4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("wr reset busy", busy, 0);
    checkOutput("wr reset done", done, 0);
    checkOutput("wr reset result", result, 0);
    checkOutput("wr reset carry", carry, 0);
    checkOutput("wr reset mem[128]", mem[128], ref_mem[128]);
    checkMemory("wr reset memory image");

    // pointer aimed at operand A
    bdWrite(8'd48, 16'h1234);
    bdWrite(8'd50, 16'd48);
    applyStimulus(1);
    waitIdle();
    checkOutput("self ptr run1", mem[48], 16'h8ACE);
    applyStimulus(1);
    waitIdle();
    checkOutput("self ptr run2", mem[48], 16'h0368);
    checkOutput("self ptr carry", carry, 1);

    // randomized runs
    for (int n = 0; n < 12; n++) begin
      bdWrite(8'd48, DW'($urandom));
      bdWrite(8'd49, DW'($urandom));
      rnd = DW'($urandom);
      if ($urandom_range(0, 2) == 0) rnd[AW-1:0] = AW'(48 + $urandom_range(0, 2));
      bdWrite(8'd50, rnd);
      applyStimulus($urandom_range(1, 3));
      waitIdle();
    end
    checkMemory("random memory image");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
